// File: rtl/tff_pkg.sv
// Shared constants for the toggle-latch / T-flip-flop counter stages.
// Default WIDTH/MODULUS live here so upstream and downstream stages agree.
package tff_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned DEFAULT_WIDTH   = 4;
  localparam int unsigned DEFAULT_MODULUS = 10;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_COUNT,
    OP_RECOVER
  } cnt_op_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result = 0;
    int unsigned rem    = (value > 0) ? value - 1 : 0;
    while (rem != 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/tff_mod_counter_t_ff.sv
// Edge-triggered T flip-flop with asynchronous active-low clear.
module t_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q,
  output logic q_bar
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

  assign q_bar = ~q;

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-N up/down counter built from T flip-flops, with cascade tc and wrap pulse.
// Define TFF_CNT_SATURATE_EN to saturate at the bounds instead of wrapping.
module tff_mod_counter
  import tff_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned MODULUS = DEFAULT_MODULUS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("tff_mod_counter: WIDTH must be in 2..16");
  end
  if (MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
    $error("tff_mod_counter: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] q_bar;
  logic [WIDTH-1:0] t;
  logic             wrap_next;
  logic             at_max;
  logic             at_zero;
  logic             at_bound;
  logic             in_range;
  cnt_op_e          op;

  assign at_max   = (q == MAX_VAL);
  assign at_zero  = &q_bar;
  assign at_bound = (up == DIR_UP) ? at_max : at_zero;
  assign in_range = ({1'b0, q} < MOD_EXT);

  assign tc = rst_n & en & at_bound;

  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      op = in_range ? OP_COUNT : OP_RECOVER;
    end
  end

  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    case (op)
      OP_LOAD: begin
        q_next = ({1'b0, d} >= MOD_EXT) ? MAX_VAL : d;
      end
      OP_COUNT: begin
        if (at_bound) begin
`ifdef TFF_CNT_SATURATE_EN
          q_next = q;
`else
          q_next    = (up == DIR_UP) ? '0 : MAX_VAL;
          wrap_next = 1'b1;
`endif
        end else begin
          q_next = (up == DIR_UP) ? q + WIDTH'(1) : q - WIDTH'(1);
        end
      end
      OP_RECOVER: begin
        q_next = '0;
      end
      default: begin
        q_next = q;
      end
    endcase
  end

  // State lives only in the T flip-flops: each bit toggles where q and q_next differ.
  assign t = q ^ q_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (t[i]),
      .q     (q[i]),
      .q_bar (q_bar[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_tff_mod_counter.sv
// Directed self-checking bench for tff_mod_counter (decade digit, cascade, MODULUS=2).
module tb_tff_mod_counter;

  logic       clk;
  logic       rst_n;
  logic       en, up, load;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc, wrap;
  logic [3:0] hi_q;
  logic       hi_tc, hi_wrap;
  logic       en2, up2, load2;
  logic [1:0] d2;
  logic [1:0] q2;
  logic       tc2, wrap2;

  int n_cmp  = 0;
  int n_fail = 0;

  tff_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .d(d),
    .q(q), .tc(tc), .wrap(wrap)
  );

  tff_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_hi (
    .clk(clk), .rst_n(rst_n), .en(tc), .up(up), .load(1'b0), .d(4'd0),
    .q(hi_q), .tc(hi_tc), .wrap(hi_wrap)
  );

  tff_mod_counter #(.WIDTH(2), .MODULUS(2)) dut_m2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .up(up2), .load(load2), .d(d2),
    .q(q2), .tc(tc2), .wrap(wrap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #3 rst_n = 1'b0;
    #2;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b1; up = 1'b0; load = 1'b0; d = '0;
    en2 = 1'b0; up2 = 1'b1; load2 = 1'b0; d2 = '0;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (q !== 4'd0) begin n_fail++; $display("FAIL reset_q: got %0d expected 0", q); end
    n_cmp++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
    n_cmp++; if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc_gated: got %b expected 0", tc); end
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_cmp++; if (tc !== 1'b1) begin n_fail++; $display("FAIL tc_down_at_zero: got %b expected 1", tc); end
    up = 1'b1;
    repeat (7) step();
    n_cmp++; if (q !== 4'd7) begin n_fail++; $display("FAIL count_to_7: got %0d expected 7", q); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (q !== 4'd0) begin n_fail++; $display("FAIL async_clear_q: got %0d expected 0", q); end
    n_cmp++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL async_clear_wrap: got %b expected 0", wrap); end
    n_cmp++; if (tc !== 1'b0) begin n_fail++; $display("FAIL async_clear_tc: got %b expected 0", tc); end
    @(negedge clk) rst_n = 1'b1;
    step();
    n_cmp++; if (q !== 4'd1) begin n_fail++; $display("FAIL first_edge_after_reset: got %0d expected 1", q); end
  endtask

  task automatic test_up_wrap();
    int eq;
    en = 1'b0; load = 1'b1; d = 4'd0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    n_cmp++; if (tc !== 1'b0) begin n_fail++; $display("FAIL up_tc_at_0: got %b expected 0", tc); end
    for (int i = 1; i <= 12; i++) begin
      step();
`ifdef TFF_CNT_SATURATE_EN
      eq = (i > 9) ? 9 : i;
`else
      eq = i % 10;
`endif
      n_cmp++; if (q !== 4'(eq)) begin n_fail++; $display("FAIL up_q[%0d]: got %0d expected %0d", i, q, eq); end
`ifdef TFF_CNT_SATURATE_EN
      n_cmp++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL up_wrap[%0d]: got %b expected 0", i, wrap); end
`else
      n_cmp++; if (wrap !== (i == 10)) begin n_fail++; $display("FAIL up_wrap[%0d]: got %b expected %b", i, wrap, i == 10); end
`endif
      n_cmp++; if (tc !== (eq == 9)) begin n_fail++; $display("FAIL up_tc[%0d]: got %b expected %b", i, tc, eq == 9); end
    end
  endtask

  task automatic test_down_wrap();
`ifdef TFF_CNT_SATURATE_EN
    int exp_q[4]    = '{1, 0, 0, 0};
    int exp_wrap[4] = '{0, 0, 0, 0};
    int exp_tc[4]   = '{0, 1, 1, 1};
`else
    int exp_q[4]    = '{1, 0, 9, 8};
    int exp_wrap[4] = '{0, 0, 1, 0};
    int exp_tc[4]   = '{0, 1, 0, 0};
`endif
    en = 1'b0; load = 1'b1; d = 4'd2;
    step();
    n_cmp++; if (q !== 4'd2) begin n_fail++; $display("FAIL down_load2: got %0d expected 2", q); end
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (q !== 4'(exp_q[i])) begin n_fail++; $display("FAIL down_q[%0d]: got %0d expected %0d", i, q, exp_q[i]); end
      n_cmp++; if (wrap !== 1'(exp_wrap[i])) begin n_fail++; $display("FAIL down_wrap[%0d]: got %b expected %0d", i, wrap, exp_wrap[i]); end
      n_cmp++; if (tc !== 1'(exp_tc[i])) begin n_fail++; $display("FAIL down_tc[%0d]: got %b expected %0d", i, tc, exp_tc[i]); end
    end
  endtask

  task automatic test_load_clamp();
    load = 1'b1; d = 4'd13; en = 1'b1; up = 1'b1;
    step();
    n_cmp++; if (q !== 4'd9) begin n_fail++; $display("FAIL clamp13_q: got %0d expected 9", q); end
    n_cmp++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL clamp13_wrap: got %b expected 0", wrap); end
    load = 1'b0;
    #1;
    n_cmp++; if (tc !== 1'b1) begin n_fail++; $display("FAIL clamp_tc: got %b expected 1", tc); end
    step();
`ifdef TFF_CNT_SATURATE_EN
    n_cmp++; if (q !== 4'd9) begin n_fail++; $display("FAIL after_clamp_q: got %0d expected 9", q); end
    n_cmp++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL after_clamp_wrap: got %b expected 0", wrap); end
`else
    n_cmp++; if (q !== 4'd0) begin n_fail++; $display("FAIL after_clamp_q: got %0d expected 0", q); end
    n_cmp++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL after_clamp_wrap: got %b expected 1", wrap); end
`endif
    load = 1'b1; d = 4'd15;
    step();
    n_cmp++; if (q !== 4'd9) begin n_fail++; $display("FAIL clamp15_q: got %0d expected 9", q); end
    n_cmp++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL load_clears_wrap: got %b expected 0", wrap); end
    d = 4'd10;
    step();
    n_cmp++; if (q !== 4'd9) begin n_fail++; $display("FAIL clamp10_q: got %0d expected 9", q); end
    d = 4'd4;
    step();
    n_cmp++; if (q !== 4'd4) begin n_fail++; $display("FAIL load4_q: got %0d expected 4", q); end
    load = 1'b0;
  endtask

  task automatic test_dir_change();
    en = 1'b1; up = 1'b1;
    step();
    n_cmp++; if (q !== 4'd5) begin n_fail++; $display("FAIL dir_up_q: got %0d expected 5", q); end
    up = 1'b0;
    step();
    n_cmp++; if (q !== 4'd4) begin n_fail++; $display("FAIL dir_down1_q: got %0d expected 4", q); end
    step();
    n_cmp++; if (q !== 4'd3) begin n_fail++; $display("FAIL dir_down2_q: got %0d expected 3", q); end
    en = 1'b0;
    repeat (2) step();
    n_cmp++; if (q !== 4'd3) begin n_fail++; $display("FAIL hold_q: got %0d expected 3", q); end
    n_cmp++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL hold_wrap: got %b expected 0", wrap); end
  endtask

  task automatic test_back_to_back();
    load2 = 1'b1; d2 = 2'd0; en2 = 1'b0;
    step();
    load2 = 1'b0; en2 = 1'b1; up2 = 1'b0;
    #1;
    n_cmp++; if (tc2 !== 1'b1) begin n_fail++; $display("FAIL m2_tc: got %b expected 1", tc2); end
    for (int i = 0; i < 3; i++) begin
      step();
`ifdef TFF_CNT_SATURATE_EN
      n_cmp++; if (q2 !== 2'd0) begin n_fail++; $display("FAIL m2_q[%0d]: got %0d expected 0", i, q2); end
      n_cmp++; if (wrap2 !== 1'b0) begin n_fail++; $display("FAIL m2_wrap[%0d]: got %b expected 0", i, wrap2); end
`else
      n_cmp++; if (q2 !== ((i % 2 == 0) ? 2'd1 : 2'd0)) begin n_fail++; $display("FAIL m2_q[%0d]: got %0d expected %0d", i, q2, (i % 2 == 0) ? 1 : 0); end
      n_cmp++; if (wrap2 !== 1'b1) begin n_fail++; $display("FAIL m2_wrap[%0d]: got %b expected 1", i, wrap2); end
      up2 = ~up2;
`endif
    end
    en2 = 1'b0;
    step();
    n_cmp++; if (wrap2 !== 1'b0) begin n_fail++; $display("FAIL m2_wrap_end: got %b expected 0", wrap2); end
  endtask

`ifndef TFF_CNT_SATURATE_EN
  task automatic test_cascade();
    int hi_wraps = 0;
    en = 1'b0; load = 1'b0; up = 1'b1;
    pulse_reset();
    en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (hi_wrap === 1'b1) hi_wraps++;
      if (i >= 98) begin
        n_cmp++; if (q !== 4'(i % 10)) begin n_fail++; $display("FAIL cascade_lo[%0d]: got %0d expected %0d", i, q, i % 10); end
        n_cmp++; if (hi_q !== 4'((i / 10) % 10)) begin n_fail++; $display("FAIL cascade_hi[%0d]: got %0d expected %0d", i, hi_q, (i / 10) % 10); end
      end
    end
    n_cmp++; if (hi_wraps !== 1) begin n_fail++; $display("FAIL cascade_hi_wraps: got %0d expected 1", hi_wraps); end
    en = 1'b0;
  endtask
`else
  task automatic test_saturate();
    load = 1'b1; d = 4'd8; en = 1'b0; up = 1'b1;
    step();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (q !== 4'd9) begin n_fail++; $display("FAIL sat_q[%0d]: got %0d expected 9", i, q); end
      n_cmp++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL sat_wrap[%0d]: got %b expected 0", i, wrap); end
      n_cmp++; if (tc !== 1'b1) begin n_fail++; $display("FAIL sat_tc[%0d]: got %b expected 1", i, tc); end
    end
    en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_clamp();
    test_dir_change();
    test_back_to_back();
`ifndef TFF_CNT_SATURATE_EN
    test_cascade();
`else
    test_saturate();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
